// File: rtl/thermal_bit_decoder.sv
// Thermal covert-channel receiver: calibrates an idle RO baseline, slices each window
// count into a bit, hunts for the preamble byte and assembles the following payload byte.
module thermal_bit_decoder #(
    parameter int         CNT_W    = 20,
    parameter int         CAL_LOG2 = 3,
    parameter int         MARGIN   = 256,
    parameter logic [7:0] PREAMBLE = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] count_in,
    input  logic             count_valid,
    input  logic             recal,
    output logic             bit_out,
    output logic             bit_valid,
    output logic [7:0]       byte_out,
    output logic             byte_valid,
    output logic [CNT_W-1:0] baseline,
    output logic             calibrated,
    output logic             synced
);
    localparam int ACC_W = CNT_W + CAL_LOG2;
    localparam logic [CNT_W:0] MARGIN_W = (CNT_W+1)'(MARGIN);

    typedef enum logic [1:0] {S_CAL, S_HUNT, S_DATA} state_t;

    state_t                state, state_next;
    logic [ACC_W-1:0]      acc;
    logic [CAL_LOG2-1:0]   cal_cnt;
    logic [CNT_W-1:0]      thr;
    logic [7:0]            sh;
    logic [7:0]            data_sh;
    logic [2:0]            bitcnt;

    logic [ACC_W-1:0]      acc_sum;
    logic [CNT_W-1:0]      base_new;
    logic                  slice_bit;
    logic [7:0]            sh_new;
    logic [7:0]            data_new;
    logic                  cal_done;
    logic                  pre_hit;
    logic                  byte_done;

    // Threshold sits MARGIN below baseline, clamped at zero for very cold/slow dies.
    function automatic logic [CNT_W-1:0] sat_sub(input logic [CNT_W-1:0] base);
        logic [CNT_W:0] diff;
        diff = {1'b0, base} - MARGIN_W;
        if ({1'b0, base} < MARGIN_W)
            return '0;
        return diff[CNT_W-1:0];
    endfunction

    always_comb begin
        acc_sum   = acc + ACC_W'(count_in);
        base_new  = acc_sum[ACC_W-1:CAL_LOG2];
        slice_bit = (count_in < thr);
        sh_new    = {sh[6:0], slice_bit};
        data_new  = {data_sh[6:0], slice_bit};
        cal_done  = (cal_cnt == '1);
        pre_hit   = (sh_new == PREAMBLE);
        byte_done = (bitcnt == 3'd7);

        state_next = state;
        if (recal) begin
            state_next = S_CAL;
        end else if (count_valid) begin
            case (state)
                S_CAL:   if (cal_done)  state_next = S_HUNT;
                S_HUNT:  if (pre_hit)   state_next = S_DATA;
                S_DATA:  if (byte_done) state_next = S_HUNT;
                default: state_next = S_CAL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_CAL;
        else
            state <= state_next;
    end

    // Sample stage: every output is registered one cycle after its count_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc        <= '0;
            cal_cnt    <= '0;
            thr        <= '0;
            sh         <= '0;
            data_sh    <= '0;
            bitcnt     <= '0;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            baseline   <= '0;
            calibrated <= 1'b0;
            synced     <= 1'b0;
        end else begin
            bit_valid  <= 1'b0;
            byte_valid <= 1'b0;
            if (recal) begin
                acc        <= '0;
                cal_cnt    <= '0;
                calibrated <= 1'b0;
                synced     <= 1'b0;
                sh         <= '0;
                bitcnt     <= '0;
            end else if (count_valid) begin
                case (state)
                    S_CAL: begin
                        if (cal_done) begin
                            baseline   <= base_new;
                            thr        <= sat_sub(base_new);
                            calibrated <= 1'b1;
                            acc        <= '0;
                            cal_cnt    <= '0;
                        end else begin
                            acc     <= acc_sum;
                            cal_cnt <= cal_cnt + 1'b1;
                        end
                    end
                    S_HUNT: begin
                        bit_out   <= slice_bit;
                        bit_valid <= 1'b1;
                        sh        <= sh_new;
                        if (pre_hit) begin
                            synced <= 1'b1;
                            bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        bit_out   <= slice_bit;
                        bit_valid <= 1'b1;
                        data_sh   <= data_new;
                        bitcnt    <= bitcnt + 1'b1;
                        if (byte_done) begin
                            byte_out   <= data_new;
                            byte_valid <= 1'b1;
                            synced     <= 1'b0;
                            sh         <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_thermal_bit_decoder.sv
// Bench for thermal_bit_decoder: vector table driven through a scoreboard queue,
// plus hand sequences for calibration, recal, back-to-back samples and async reset.
module tb_thermal_bit_decoder;
    localparam int CNT_W = 20;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [CNT_W-1:0] count_in = '0;
    logic             count_valid = 1'b0;
    logic             recal = 1'b0;
    logic             bit_out, bit_valid, byte_valid, calibrated, synced;
    logic [7:0]       byte_out;
    logic [CNT_W-1:0] baseline;

    typedef struct {
        logic [CNT_W-1:0] count;
        logic             b;
        logic             sync;
        logic             bv;
        logic [7:0]       byt;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    thermal_bit_decoder #(.CNT_W(CNT_W), .CAL_LOG2(2), .MARGIN(100), .PREAMBLE(8'hA5)) dut (
        .clk(clk), .reset(reset), .count_in(count_in), .count_valid(count_valid),
        .recal(recal), .bit_out(bit_out), .bit_valid(bit_valid), .byte_out(byte_out),
        .byte_valid(byte_valid), .baseline(baseline), .calibrated(calibrated), .synced(synced)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected record for one bit; hot window (bit 1) is a low count.
    task automatic add_bit(input logic b, input logic s, input logic bv, input logic [7:0] byt);
        vec_t v;
        v.count = b ? 20'd800 : 20'd1000;
        v.b = b; v.sync = s; v.bv = bv; v.byt = byt;
        vecs.push_back(v);
    endtask

    task automatic add_preamble();
        logic [7:0] p;
        p = 8'hA5;
        for (int i = 7; i >= 0; i--) add_bit(p[i], (i == 0), 1'b0, 8'h00);
    endtask

    task automatic add_data(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) add_bit(d[i], (i != 0), (i == 0), d);
    endtask

    task automatic send_vec(input vec_t v);
        vec_t e;
        int   waited;
        exp_q.push_back(v);
        @(negedge clk);
        count_in = v.count;
        count_valid = 1'b1;
        @(negedge clk);
        count_valid = 1'b0;
        waited = 0;
        while (!bit_valid && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        e = exp_q.pop_front();
        if (!bit_valid) begin
            check("bit_valid_timeout", 32'(bit_valid), 32'd1);
        end else begin
            check("bit_latency", 32'(waited), 32'd0);
            check("bit_out", 32'(bit_out), 32'(e.b));
            check("synced", 32'(synced), 32'(e.sync));
            check("byte_valid", 32'(byte_valid), 32'(e.bv));
            if (e.bv) check("byte_out", 32'(byte_out), 32'(e.byt));
        end
    endtask

    task automatic cal_sample(input logic [CNT_W-1:0] c);
        @(negedge clk);
        count_in = c;
        count_valid = 1'b1;
        @(negedge clk);
        count_valid = 1'b0;
        check("cal_no_bit_valid", 32'(bit_valid), 32'd0);
    endtask

    task automatic pulse_recal();
        @(negedge clk);
        recal = 1'b1;
        @(negedge clk);
        recal = 1'b0;
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) send_vec(vecs[i]);
        vecs.delete();
    endtask

    initial begin
        #3 reset = 1'b1;
        #1;
        check("rst_bit_out", 32'(bit_out), 0);
        check("rst_bit_valid", 32'(bit_valid), 0);
        check("rst_byte_out", 32'(byte_out), 0);
        check("rst_byte_valid", 32'(byte_valid), 0);
        check("rst_baseline", 32'(baseline), 0);
        check("rst_calibrated", 32'(calibrated), 0);
        check("rst_synced", 32'(synced), 0);
        #12 reset = 1'b0;

        // Calibration: mean of 1000,1002,998,1000 = 1000, threshold 900
        cal_sample(20'd1000);
        cal_sample(20'd1002);
        cal_sample(20'd998);
        check("cal_not_yet", 32'(calibrated), 0);
        cal_sample(20'd1000);
        check("cal_done", 32'(calibrated), 1);
        check("cal_baseline", 32'(baseline), 32'd1000);

        // Threshold boundary, then preamble + 0x3C, then noise 1,0,1 + preamble + 0x5A
        vecs.push_back('{count: 20'd899, b: 1'b1, sync: 1'b0, bv: 1'b0, byt: 8'h00});
        vecs.push_back('{count: 20'd900, b: 1'b0, sync: 1'b0, bv: 1'b0, byt: 8'h00});
        add_preamble();
        add_data(8'h3C);
        add_bit(1'b1, 1'b0, 1'b0, 8'h00);
        add_bit(1'b0, 1'b0, 1'b0, 8'h00);
        add_bit(1'b1, 1'b0, 1'b0, 8'h00);
        add_preamble();
        add_data(8'h5A);
        run_vecs();
        check("byte_hold", 32'(byte_out), 32'h5A);

        // recal together with count_valid mid-DATA: sample discarded
        add_preamble();
        add_bit(1'b1, 1'b1, 1'b0, 8'h00);
        add_bit(1'b0, 1'b1, 1'b0, 8'h00);
        run_vecs();
        @(negedge clk);
        count_in = 20'd800;
        count_valid = 1'b1;
        recal = 1'b1;
        @(negedge clk);
        count_valid = 1'b0;
        recal = 1'b0;
        check("recal_no_bit_valid", 32'(bit_valid), 0);
        check("recal_calibrated", 32'(calibrated), 0);
        check("recal_synced", 32'(synced), 0);
        check("recal_baseline_hold", 32'(baseline), 32'd1000);
        check("recal_byte_hold", 32'(byte_out), 32'h5A);
        cal_sample(20'd2000);
        cal_sample(20'd2000);
        cal_sample(20'd2000);
        check("recal_needs_four", 32'(calibrated), 0);
        cal_sample(20'd2000);
        check("recal_done", 32'(calibrated), 1);
        check("recal_baseline", 32'(baseline), 32'd2000);

        // Back-to-back samples against threshold 1900
        @(negedge clk);
        count_in = 20'd1800;
        count_valid = 1'b1;
        @(negedge clk);
        check("b2b_first_valid", 32'(bit_valid), 1);
        check("b2b_first_bit", 32'(bit_out), 1);
        count_in = 20'd2000;
        @(negedge clk);
        count_valid = 1'b0;
        check("b2b_second_valid", 32'(bit_valid), 1);
        check("b2b_second_bit", 32'(bit_out), 0);
        @(negedge clk);
        check("b2b_pulse_end", 32'(bit_valid), 0);

        // Baseline 50 with margin 100 saturates threshold to 0: every bit 0, no sync
        pulse_recal();
        for (int i = 0; i < 4; i++) cal_sample(20'd50);
        check("sat_baseline", 32'(baseline), 32'd50);
        for (int i = 0; i < 8; i++)
            vecs.push_back('{count: (i % 2 == 0) ? 20'd0 : 20'd1000, b: 1'b0, sync: 1'b0,
                             bv: 1'b0, byt: 8'h00});
        run_vecs();
        check("sat_no_sync", 32'(synced), 0);

        // Async reset mid-frame clears everything at once
        pulse_recal();
        for (int i = 0; i < 4; i++) cal_sample(20'd1000);
        add_preamble();
        add_bit(1'b1, 1'b1, 1'b0, 8'h00);
        add_bit(1'b1, 1'b1, 1'b0, 8'h00);
        run_vecs();
        #2 reset = 1'b1;
        #1;
        check("arst_bit_out", 32'(bit_out), 0);
        check("arst_synced", 32'(synced), 0);
        check("arst_calibrated", 32'(calibrated), 0);
        check("arst_baseline", 32'(baseline), 0);
        check("arst_byte_out", 32'(byte_out), 0);
        @(negedge clk);
        reset = 1'b0;
        cal_sample(20'd800);
        check("arst_no_byte_valid", 32'(byte_valid), 0);
        check("arst_still_cal", 32'(calibrated), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
